// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: two-read / one-write register file with registered read ports.
// Optional write-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
// Without it, a read of the entry being written returns the old value.
// With ZERO_REG != 0, entry 0 is hardwired to zero.
module reg_file_2r1w #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ZERO_REG = 0,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re_a,
  input  logic             re_b,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             rvalid_a,
  output logic             rvalid_b
);

  localparam int unsigned AW1 = AW + 1;
  localparam logic [AW1-1:0] DEPTH_W = AW1'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
  logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
  logic             rvalid_a_q, rvalid_a_d;
  logic             rvalid_b_q, rvalid_b_d;
  logic             zero_en;
  logic             wr_ok, ok_a, ok_b, byp_a, byp_b;

  // Address qualification: range checks, zero-register masking and forwarding hits.
  always_comb begin
    zero_en = (ZERO_REG != 0);
    wr_ok   = we && !clr && ({1'b0, waddr} < DEPTH_W) && !(zero_en && (waddr == '0));
    ok_a    = ({1'b0, raddr_a} < DEPTH_W) && !(zero_en && (raddr_a == '0));
    ok_b    = ({1'b0, raddr_b} < DEPTH_W) && !(zero_en && (raddr_b == '0));
`ifdef REG_FILE_BYPASS_EN
    byp_a   = wr_ok && (waddr == raddr_a);
    byp_b   = wr_ok && (waddr == raddr_b);
`else
    byp_a   = 1'b0;
    byp_b   = 1'b0;
`endif
  end

  // Next-state of the storage array: clear wins over write.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = clr ? '0 : mem_q[i];
    end
    if (wr_ok) begin
      mem_d[waddr] = wdata;
    end
  end

  // Read ports: capture on enable, otherwise hold data and drop valid.
  always_comb begin
    rdata_a_d  = rdata_a_q;
    rdata_b_d  = rdata_b_q;
    rvalid_a_d = re_a;
    rvalid_b_d = re_b;
    if (re_a) begin
      if (clr || !ok_a) rdata_a_d = '0;
      else if (byp_a)   rdata_a_d = wdata;
      else              rdata_a_d = mem_q[raddr_a];
    end
    if (re_b) begin
      if (clr || !ok_b) rdata_b_d = '0;
      else if (byp_b)   rdata_b_d = wdata;
      else              rdata_b_d = mem_q[raddr_b];
    end
  end

  // State registers with asynchronous clear of everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
    end
  end

  assign rdata_a  = rdata_a_q;
  assign rdata_b  = rdata_b_q;
  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench for reg_file_2r1w: default instance plus a DEPTH=6, ZERO_REG=1 instance.
module tb_reg_file_2r1w;

  logic clk, rst_n;

  // Default instance (WIDTH=8, DEPTH=8, ZERO_REG=0)
  logic       clr, we, re_a, re_b;
  logic [2:0] waddr, raddr_a, raddr_b;
  logic [7:0] wdata, rdata_a, rdata_b;
  logic       rvalid_a, rvalid_b;

  // Zero-register instance (WIDTH=8, DEPTH=6, ZERO_REG=1)
  logic       z_clr, z_we, z_re_a, z_re_b;
  logic [2:0] z_waddr, z_raddr_a, z_raddr_b;
  logic [7:0] z_wdata, z_rdata_a, z_rdata_b;
  logic       z_rvalid_a, z_rvalid_b;

  logic [7:0] qa0[$], qb0[$], qa1[$], qb1[$];
  int total = 0;
  int bad   = 0;

`ifdef REG_FILE_BYPASS_EN
  localparam logic [7:0] RDW_EXP = 8'h22;
`else
  localparam logic [7:0] RDW_EXP = 8'h11;
`endif

  reg_file_2r1w #(.WIDTH(8), .DEPTH(8), .ZERO_REG(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .re_b(re_b), .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b)
  );

  reg_file_2r1w #(.WIDTH(8), .DEPTH(6), .ZERO_REG(1)) u_dut_z (
    .clk(clk), .rst_n(rst_n), .clr(z_clr), .we(z_we), .waddr(z_waddr), .wdata(z_wdata),
    .re_a(z_re_a), .re_b(z_re_b), .raddr_a(z_raddr_a), .raddr_b(z_raddr_b),
    .rdata_a(z_rdata_a), .rdata_b(z_rdata_b), .rvalid_a(z_rvalid_a), .rvalid_b(z_rvalid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic spurious(input string name);
    total++;
    bad++;
    $display("FAIL %s: got rvalid=1 want no pending read", name);
  endtask

  // Monitor: pop expected data whenever a port presents rvalid.
  always @(negedge clk) begin
    if (rvalid_a)   begin if (qa0.size() == 0) spurious("rd_a0"); else chk("rd_a0", rdata_a,   qa0.pop_front()); end
    if (rvalid_b)   begin if (qb0.size() == 0) spurious("rd_b0"); else chk("rd_b0", rdata_b,   qb0.pop_front()); end
    if (z_rvalid_a) begin if (qa1.size() == 0) spurious("rd_a1"); else chk("rd_a1", z_rdata_a, qa1.pop_front()); end
    if (z_rvalid_b) begin if (qb1.size() == 0) spurious("rd_b1"); else chk("rd_b1", z_rdata_b, qb1.pop_front()); end
  end

  // One clock; pulses are dropped after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    clr = 1'b0; we = 1'b0; re_a = 1'b0; re_b = 1'b0;
    z_clr = 1'b0; z_we = 1'b0; z_re_a = 1'b0; z_re_b = 1'b0;
  endtask

  task automatic wr0(input logic [2:0] a, input logic [7:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
  endtask

  task automatic rd0(input logic ea, input logic [2:0] aa, input logic eb, input logic [2:0] ab,
                     input logic [7:0] xa, input logic [7:0] xb);
    re_a = ea; raddr_a = aa; re_b = eb; raddr_b = ab;
    if (ea) qa0.push_back(xa);
    if (eb) qb0.push_back(xb);
    step();
  endtask

  task automatic wr1(input logic [2:0] a, input logic [7:0] d);
    z_we = 1'b1; z_waddr = a; z_wdata = d;
    step();
  endtask

  task automatic rd1(input logic ea, input logic [2:0] aa, input logic eb, input logic [2:0] ab,
                     input logic [7:0] xa, input logic [7:0] xb);
    z_re_a = ea; z_raddr_a = aa; z_re_b = eb; z_raddr_b = ab;
    if (ea) qa1.push_back(xa);
    if (eb) qb1.push_back(xb);
    step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    clr = 1'b0; we = 1'b0; re_a = 1'b0; re_b = 1'b0;
    waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
    z_clr = 1'b0; z_we = 1'b0; z_re_a = 1'b0; z_re_b = 1'b0;
    z_waddr = '0; z_wdata = '0; z_raddr_a = '0; z_raddr_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata_a",  rdata_a, 8'h00);
    chk("rst_rdata_b",  rdata_b, 8'h00);
    chk("rst_rvalid_a", 8'(rvalid_a), 8'h00);
    chk("rst_rvalid_b", 8'(rvalid_b), 8'h00);
    rst_n = 1'b1;

    // Write then read, one-cycle latency
    wr0(3'd3, 8'hA5);
    rd0(1'b1, 3'd3, 1'b0, 3'd0, 8'hA5, 8'h00);

    // Dual port, same address
    wr0(3'd1, 8'h3C);
    rd0(1'b1, 3'd1, 1'b1, 3'd1, 8'h3C, 8'h3C);
    chk("dual_rvalid", 8'({rvalid_a, rvalid_b}), 8'h03);

    // Idle: data holds, valid drops
    step();
    chk("hold_rdata_a",  rdata_a, 8'h3C);
    chk("hold_rvalid_a", 8'(rvalid_a), 8'h00);

    // Read-during-write on port B
    wr0(3'd5, 8'h11);
    we = 1'b1; waddr = 3'd5; wdata = 8'h22;
    rd0(1'b0, 3'd0, 1'b1, 3'd5, 8'h00, RDW_EXP);
    rd0(1'b0, 3'd0, 1'b1, 3'd5, 8'h00, 8'h22);

    // Clear with simultaneous write and read, then sweep all entries
    wr0(3'd2, 8'h77);
    clr = 1'b1; we = 1'b1; waddr = 3'd2; wdata = 8'hFF;
    rd0(1'b1, 3'd2, 1'b0, 3'd0, 8'h00, 8'h00);
    for (int i = 0; i < 8; i += 2) begin
      rd0(1'b1, 3'(i), 1'b1, 3'(i + 1), 8'h00, 8'h00);
    end

    // Asynchronous reset mid-cycle with a read pending
    wr0(3'd3, 8'hA5);
    rd0(1'b1, 3'd3, 1'b0, 3'd0, 8'hA5, 8'h00);
    re_a = 1'b1; raddr_a = 3'd3;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_rdata_a",  rdata_a, 8'h00);
    chk("arst_rdata_b",  rdata_b, 8'h00);
    chk("arst_rvalid_a", 8'(rvalid_a), 8'h00);
    chk("arst_rvalid_b", 8'(rvalid_b), 8'h00);
    @(posedge clk);
    #1;
    chk("arst_no_valid", 8'(rvalid_a), 8'h00);
    re_a = 1'b0;
    rst_n = 1'b1;
    rd0(1'b1, 3'd3, 1'b1, 3'd5, 8'h00, 8'h00);
    rd0(1'b1, 3'd1, 1'b1, 3'd2, 8'h00, 8'h00);

    // Zero register and out-of-range handling (DEPTH=6)
    wr1(3'd1, 8'h55);
    wr1(3'd0, 8'h7E);
    wr1(3'd7, 8'h7E);
    rd1(1'b1, 3'd0, 1'b1, 3'd7, 8'h00, 8'h00);
    rd1(1'b1, 3'd1, 1'b1, 3'd5, 8'h55, 8'h00);
    z_we = 1'b1; z_waddr = 3'd0; z_wdata = 8'h7E;
    rd1(1'b1, 3'd0, 1'b0, 3'd0, 8'h00, 8'h00);
    z_we = 1'b1; z_waddr = 3'd6; z_wdata = 8'h7E;
    rd1(1'b1, 3'd6, 1'b1, 3'd1, 8'h00, 8'h55);

    // All expected reads must have been seen
    step();
    step();
    chk("drain_a0", 8'(qa0.size()), 8'h00);
    chk("drain_b0", 8'(qb0.size()), 8'h00);
    chk("drain_a1", 8'(qa1.size()), 8'h00);
    chk("drain_b1", 8'(qb1.size()), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
REG_FILE_2R1W -- requirements
Module: reg_file_2r1w

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data bits per entry, legal 1..64.
REQ-002 The block SHALL have parameter DEPTH, default 8: number of entries, legal 2..256, power of two not required.
REQ-003 The block SHALL have parameter ZERO_REG, default 0: when 1, entry 0 is hardwired to zero.
REQ-004 The block SHALL derive localparam AW = ceil(log2(DEPTH)), the address width.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port clr, input, 1 bit: synchronous clear of all entries.
REQ-008 The block SHALL have port we, input, 1 bit: write enable.
REQ-009 The block SHALL have port waddr, input, AW bits: write address.
REQ-010 The block SHALL have port wdata, input, WIDTH bits: write data.
REQ-011 The block SHALL have ports re_a and re_b, input, 1 bit each: read enables, ports A and B.
REQ-012 The block SHALL have ports raddr_a and raddr_b, input, AW bits each: read addresses.
REQ-013 The block SHALL have ports rdata_a and rdata_b, output, WIDTH bits each: registered read data.
REQ-014 The block SHALL have ports rvalid_a and rvalid_b, output, 1 bit each: high for exactly one cycle when the matching rdata is new.

Function
REQ-015 Write: on a clk edge with we=1, clr=0 and waddr<DEPTH, entry[waddr] SHALL take wdata.
REQ-016 A write with waddr>=DEPTH SHALL be ignored, with no entry changed.
REQ-017 With ZERO_REG=1, writes to entry 0 SHALL be ignored and reads of entry 0 SHALL return 0.
REQ-018 Read latency: re_x=1 at edge N SHALL update rdata_x and assert rvalid_x=1 after edge N, i.e. 1 cycle.
REQ-019 With re_x=0, rdata_x SHALL hold its last value and rvalid_x SHALL be 0.
REQ-020 A read with raddr_x>=DEPTH SHALL return 0 with rvalid_x=1.
REQ-021 Ports A and B SHALL be independent; the same address on both ports SHALL return identical data.
REQ-022 clr=1 SHALL zero every entry at the edge; clr SHALL take priority over a simultaneous we.
REQ-023 A read in the same cycle as clr SHALL return 0.
REQ-024 A read-during-write to the same address SHALL follow the rules in Configuration.
REQ-025 Entries SHALL hold their value indefinitely absent we, clr or reset.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for a clk edge, set every entry, rdata_a and rdata_b to 0, and rvalid_a and rvalid_b to 0.
REQ-027 Deassertion of rst_n SHALL be treated as synchronous by the integrator; the block SHALL accept we/re on the first edge after rst_n rises.
REQ-028 Reset mid-operation SHALL discard any in-flight read, so rvalid does not fire for it.

Configuration
REQ-029 Macro REG_FILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-030 When REG_FILE_BYPASS_EN is defined, a read of the address being written in the same cycle (we=1, valid address, clr=0) SHALL return the new wdata.
REQ-031 When REG_FILE_BYPASS_EN is undefined, a read of the address being written in the same cycle SHALL return the old entry value; the new value SHALL be visible from the next read.
REQ-032 Bypass SHALL never forward to entry 0 when ZERO_REG=1, nor to an out-of-range address.

Verification
REQ-033 The bench SHALL run reset: rst_n=0 mid-cycle after writes -> all rdata=0, rvalid=0 immediately; any read of any entry then returns 0.
REQ-034 The bench SHALL run write then read: we, waddr=3, wdata=8'hA5; next cycle re_a with raddr_a=3 -> rdata_a=8'hA5 with rvalid_a=1 one cycle later.
REQ-035 The bench SHALL run read-during-write: entry 5=8'h11; same cycle we with waddr=5, wdata=8'h22 and re_b with raddr_b=5 -> rdata_b=8'h22 with the macro, 8'h11 without it.
REQ-036 The bench SHALL run clr with write: clr=1 and we with waddr=2, wdata=8'hFF in the same cycle -> entry 2 reads 0 afterward; all entries read 0.
REQ-037 The bench SHALL run ZERO_REG=1 with DEPTH=6: write 8'h7E to addr 0 and to addr 7 -> reads of addr 0 and addr 7 return 0; other entries are unchanged.
REQ-038 The bench SHALL run dual port: raddr_a=1 and raddr_b=1 with entry 1=8'h3C -> both ports return 8'h3C with both rvalid=1 in the same cycle.
